// File: rtl/adc_avg_pkg.sv
// rtl/adc_avg_pkg.sv - shared constants, slot map and FSM state type for adc_chan_avg
package adc_avg_pkg;

  localparam int NUM_SLOTS = 5;
  localparam int SAMPLE_W  = 12;
  localparam int CHAN_W    = 5;

  // Sequencer channel numbers that own an averaging slot
  localparam logic [CHAN_W-1:0] SLOT0_CH = 5'd1;
  localparam logic [CHAN_W-1:0] SLOT1_CH = 5'd2;
  localparam logic [CHAN_W-1:0] SLOT2_CH = 5'd3;
  localparam logic [CHAN_W-1:0] SLOT3_CH = 5'd4;
  localparam logic [CHAN_W-1:0] SLOT4_CH = 5'd6;

  // Sticky error bit positions
  localparam int ERR_DISCARD    = 0;
  localparam int ERR_SOP_IN_PKT = 1;
  localparam int ERR_NO_SOP     = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOP = 2'd1,
    ST_IN_PKT   = 2'd2
  } avg_state_e;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } slot_map_t;

  // Channel number to slot index; unmapped channels return hit=0
  function automatic slot_map_t chan_to_slot(input logic [CHAN_W-1:0] ch);
    slot_map_t m;
    m.hit = 1'b1;
    m.idx = 3'd0;
    case (ch)
      SLOT0_CH: m.idx = 3'd0;
      SLOT1_CH: m.idx = 3'd1;
      SLOT2_CH: m.idx = 3'd2;
      SLOT3_CH: m.idx = 3'd3;
      SLOT4_CH: m.idx = 3'd4;
      default:  m.hit = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/adc_chan_avg_if.sv
// rtl/adc_chan_avg_if.sv - ADC sequencer response stream (no backpressure)
interface adc_chan_avg_if;
  logic                                valid;
  logic [adc_avg_pkg::CHAN_W-1:0]      channel;
  logic [adc_avg_pkg::SAMPLE_W-1:0]    data;
  logic                                startofpacket;
  logic                                endofpacket;

  modport master (
    output valid, channel, data, startofpacket, endofpacket
  );

  modport slave (
    input valid, channel, data, startofpacket, endofpacket
  );
endinterface

// File: rtl/adc_avg_slot.sv
// rtl/adc_avg_slot.sv - one averaging slot: stage, seen bit, accumulator, scaled output (ADC_AVG_ROUND_EN selects rounding)
module adc_avg_slot
  import adc_avg_pkg::*;
#(
  parameter int AVG_LOG2 = 3
) (
  input  logic                clk_core,
  input  logic                reset,
  input  logic                flush,
  input  logic                restart,
  input  logic                pkt_end,
  input  logic                load,
  input  logic                commit,
  input  logic                publish,
  input  logic [SAMPLE_W-1:0] data,
  output logic                seen,
  output logic [SAMPLE_W-1:0] avg
);

  // Holds at most 2^AVG_LOG2 - 1 committed samples plus the one in flight
  localparam int AW = SAMPLE_W + AVG_LOG2;

  logic [SAMPLE_W-1:0] stage_q, stage_d, stage_nxt;
  logic [SAMPLE_W-1:0] avg_q, avg_d;
  logic                seen_q, seen_d;
  logic [AW-1:0]       acc_q, acc_d, sum;
`ifdef ADC_AVG_ROUND_EN
  logic [AW:0]         rounded;
`endif

  // Commit uses the sample arriving on the EOP beat itself, hence stage_nxt
  always_comb begin
    stage_nxt = load ? data : stage_q;
    sum       = acc_q + AW'(stage_nxt);
`ifdef ADC_AVG_ROUND_EN
    rounded   = {1'b0, sum} + ((AW+1)'(1) << (AVG_LOG2 - 1));
    avg_d     = publish ? SAMPLE_W'(rounded >> AVG_LOG2) : avg_q;
`else
    avg_d     = publish ? SAMPLE_W'(sum >> AVG_LOG2) : avg_q;
`endif
    stage_d   = flush ? '0 : stage_nxt;
    seen_d    = (flush || pkt_end) ? 1'b0 : ((seen_q & ~restart) | load);
    acc_d     = acc_q;
    if (flush || publish) begin
      acc_d = '0;
    end else if (commit) begin
      acc_d = sum;
    end
  end

  // Slot state registers; the published average survives flush
  always_ff @(posedge clk_core) begin
    if (reset) begin
      stage_q <= '0;
      seen_q  <= 1'b0;
      acc_q   <= '0;
      avg_q   <= '0;
    end else begin
      stage_q <= stage_d;
      seen_q  <= seen_d;
      acc_q   <= acc_d;
      avg_q   <= avg_d;
    end
  end

  assign seen = seen_q;
  assign avg  = avg_q;

endmodule

// File: rtl/adc_chan_avg.sv
// rtl/adc_chan_avg.sv - packet-framed per-channel ADC averager (ADC_AVG_ROUND_EN enables round-half-up)
module adc_chan_avg
  import adc_avg_pkg::*;
#(
  parameter int AVG_LOG2 = 3  // legal 1..6
) (
  input  logic                clk_core,
  input  logic                reset,
  input  logic                enable,
  adc_chan_avg_if.slave       rsp,
  input  logic                err_clr,
  output logic [SAMPLE_W-1:0] avg_ch0,
  output logic [SAMPLE_W-1:0] avg_ch1,
  output logic [SAMPLE_W-1:0] avg_ch2,
  output logic [SAMPLE_W-1:0] avg_ch3,
  output logic [SAMPLE_W-1:0] avg_ch4,
  output logic                avg_valid,
  output logic [7:0]          avg_seq,
  output logic [2:0]          err
);

  avg_state_e            state_q, state_d;
  logic                  bad_q, bad_d;
  logic [AVG_LOG2-1:0]   cnt_q, cnt_d;
  logic [2:0]            err_q, err_d;
  logic [7:0]            seq_q, seq_d;
  logic                  valid_q, valid_d;

  logic                  flush, restart, take, pkt_end, commit, publish, bad_now;
  logic [NUM_SLOTS-1:0]  load, seen, eff_seen, mask;
  slot_map_t             map;
  logic [SAMPLE_W-1:0]   avg_vec [NUM_SLOTS];

  // Framing FSM next-state plus slot strobes for the current beat
  always_comb begin
    state_d  = state_q;
    bad_d    = bad_q;
    cnt_d    = cnt_q;
    seq_d    = seq_q;
    valid_d  = 1'b0;
    err_d    = err_clr ? '0 : err_q;
    flush    = 1'b0;
    restart  = 1'b0;
    take     = 1'b0;
    pkt_end  = 1'b0;
    commit   = 1'b0;
    publish  = 1'b0;
    bad_now  = 1'b0;
    load     = '0;
    eff_seen = '0;
    mask     = '0;
    map      = chan_to_slot(rsp.channel);

    if (!enable) begin
      state_d = ST_IDLE;
      flush   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT_SOP;
          flush   = 1'b1;
        end
        ST_WAIT_SOP: begin
          if (rsp.valid) begin
            if (rsp.startofpacket) begin
              restart = 1'b1;
              take    = 1'b1;
            end else begin
              err_d[ERR_NO_SOP] = 1'b1;
            end
          end
        end
        ST_IN_PKT: begin
          if (rsp.valid) begin
            take = 1'b1;
            if (rsp.startofpacket) begin
              restart               = 1'b1;
              err_d[ERR_SOP_IN_PKT] = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A restart forgets the partial packet before this beat is applied
    if (take) begin
      eff_seen = restart ? '0 : seen;
      bad_now  = restart ? 1'b0 : bad_q;
      if (map.hit) begin
        if (eff_seen[map.idx]) begin
          bad_now = 1'b1;
        end else begin
          load[map.idx] = 1'b1;
        end
      end
      mask = eff_seen | load;
      if (rsp.endofpacket) begin
        pkt_end = 1'b1;
        state_d = ST_WAIT_SOP;
        bad_d   = 1'b0;
        if ((&mask) && !bad_now) begin
          commit = 1'b1;
          if (&cnt_q) begin
            publish = 1'b1;
            cnt_d   = '0;
            seq_d   = seq_q + 8'd1;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + AVG_LOG2'(1);
          end
        end else begin
          err_d[ERR_DISCARD] = 1'b1;
        end
      end else begin
        state_d = ST_IN_PKT;
        bad_d   = bad_now;
      end
    end

    if (flush) begin
      cnt_d = '0;
      bad_d = 1'b0;
    end
  end

  // Control and output registers
  always_ff @(posedge clk_core) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bad_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= '0;
      seq_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bad_q   <= bad_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      seq_q   <= seq_d;
      valid_q <= valid_d;
    end
  end

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    adc_avg_slot #(
      .AVG_LOG2 (AVG_LOG2)
    ) u_slot (
      .clk_core (clk_core),
      .reset    (reset),
      .flush    (flush),
      .restart  (restart),
      .pkt_end  (pkt_end),
      .load     (load[s]),
      .commit   (commit),
      .publish  (publish),
      .data     (rsp.data),
      .seen     (seen[s]),
      .avg      (avg_vec[s])
    );
  end

  assign avg_ch0   = avg_vec[0];
  assign avg_ch1   = avg_vec[1];
  assign avg_ch2   = avg_vec[2];
  assign avg_ch3   = avg_vec[3];
  assign avg_ch4   = avg_vec[4];
  assign avg_valid = valid_q;
  assign avg_seq   = seq_q;
  assign err       = err_q;

endmodule

// File: tb/tb_adc_chan_avg.sv
// tb/tb_adc_chan_avg.sv - directed/random bench for adc_chan_avg with packet-level reference model
module tb_adc_chan_avg;

  localparam int N   = 3;
  localparam int WIN = 1 << N;

  logic        clk_core = 1'b0;
  logic        reset, enable, err_clr;
  logic [11:0] avg_ch0, avg_ch1, avg_ch2, avg_ch3, avg_ch4;
  logic        avg_valid;
  logic [7:0]  avg_seq;
  logic [2:0]  err;

  adc_chan_avg_if rsp ();

  adc_chan_avg #(.AVG_LOG2(N)) dut (
    .clk_core  (clk_core),
    .reset     (reset),
    .enable    (enable),
    .rsp       (rsp),
    .err_clr   (err_clr),
    .avg_ch0   (avg_ch0),
    .avg_ch1   (avg_ch1),
    .avg_ch2   (avg_ch2),
    .avg_ch3   (avg_ch3),
    .avg_ch4   (avg_ch4),
    .avg_valid (avg_valid),
    .avg_seq   (avg_seq),
    .err       (err)
  );

  always #10 clk_core = ~clk_core;

  int checks = 0;
  int failures = 0;

  // Packet-level reference model
  int          CHAN [5] = '{1, 2, 3, 4, 6};
  int          sum_m [5];
  int          cnt_m;
  logic [11:0] avg_m [5];
  int          seq_m;
  logic [2:0]  err_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int slot_of(input int ch);
    for (int i = 0; i < 5; i++) if (CHAN[i] == ch) return i;
    return -1;
  endfunction

  function automatic logic [11:0] scale(input int total);
`ifdef ADC_AVG_ROUND_EN
    return 12'((total + WIN / 2) / WIN);
`else
    return 12'(total / WIN);
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 5; i++) sum_m[i] = 0;
    cnt_m = 0;
  endtask

  task automatic model_reset();
    model_clear();
    for (int i = 0; i < 5; i++) avg_m[i] = '0;
    seq_m = 0;
    err_m = '0;
  endtask

  task automatic model_commit(input int smp [5], output bit pub);
    pub = 0;
    for (int i = 0; i < 5; i++) sum_m[i] += smp[i];
    cnt_m++;
    if (cnt_m == WIN) begin
      for (int i = 0; i < 5; i++) avg_m[i] = scale(sum_m[i]);
      seq_m = (seq_m + 1) % 256;
      model_clear();
      pub = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic beat(input int ch, input int d, input bit sop, input bit eop);
    rsp.valid         = 1'b1;
    rsp.channel       = 5'(ch);
    rsp.data          = 12'(d);
    rsp.startofpacket = sop;
    rsp.endofpacket   = eop;
    tick();
    rsp.valid         = 1'b0;
    rsp.startofpacket = 1'b0;
    rsp.endofpacket   = 1'b0;
  endtask

  task automatic check_outs(input string tag, input bit exp_valid);
    check({tag, ".avg_valid"}, avg_valid, exp_valid);
    check({tag, ".avg_ch0"}, avg_ch0, avg_m[0]);
    check({tag, ".avg_ch1"}, avg_ch1, avg_m[1]);
    check({tag, ".avg_ch2"}, avg_ch2, avg_m[2]);
    check({tag, ".avg_ch3"}, avg_ch3, avg_m[3]);
    check({tag, ".avg_ch4"}, avg_ch4, avg_m[4]);
    check({tag, ".avg_seq"}, avg_seq, seq_m[7:0]);
    check({tag, ".err"}, err, err_m);
  endtask

  // Sends one SOP..EOP packet; the model commits it only if every mapped channel appears exactly once
  task automatic send_pkt(input string tag, input int chs [$], input int dat [$]);
    int occ [5];
    int smp [5];
    int n;
    int s;
    bit ok;
    bit pub;
    n = chs.size();
    for (int i = 0; i < 5; i++) begin occ[i] = 0; smp[i] = 0; end
    for (int i = 0; i < n; i++) begin
      s = slot_of(chs[i]);
      if (s >= 0) begin
        if (occ[s] == 0) smp[s] = dat[i];
        occ[s]++;
      end
      beat(chs[i], dat[i], i == 0, i == n - 1);
      if (i != n - 1) check({tag, ".mid_valid"}, avg_valid, 1'b0);
    end
    ok = 1;
    for (int i = 0; i < 5; i++) if (occ[i] != 1) ok = 0;
    pub = 0;
    if (ok) model_commit(smp, pub);
    else err_m[0] = 1'b1;
    check_outs(tag, pub);
  endtask

  // Builds a complete packet in random slot order with some unmapped beats mixed in
  task automatic make_good(input int d [5], input int junk, output int chs [$], output int dat [$]);
    int ord [5];
    int j, t, ch;
    chs = {};
    dat = {};
    for (int i = 0; i < 5; i++) ord[i] = i;
    for (int i = 4; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = ord[i]; ord[i] = ord[j]; ord[j] = t;
    end
    for (int i = 0; i < 5; i++) begin
      chs.push_back(CHAN[ord[i]]);
      dat.push_back(d[ord[i]]);
    end
    for (int k = 0; k < junk; k++) begin
      do ch = int'($urandom_range(0, 31)); while (slot_of(ch) >= 0);
      j = int'($urandom_range(0, chs.size()));
      chs.insert(j, ch);
      dat.insert(j, int'($urandom_range(0, 4095)));
    end
  endtask

  task automatic rand_data(output int d [5]);
    for (int i = 0; i < 5; i++) d[i] = int'($urandom_range(0, 4095));
  endtask

  task automatic good_pkt(input string tag, input int junk);
    int d [5];
    int chs [$];
    int dat [$];
    rand_data(d);
    make_good(d, junk, chs, dat);
    send_pkt(tag, chs, dat);
  endtask

  int d5 [5];
  int cq [$];
  int dq [$];

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    err_clr = 1'b0;
    rsp.valid = 1'b0;
    rsp.channel = '0;
    rsp.data = '0;
    rsp.startofpacket = 1'b0;
    rsp.endofpacket = 1'b0;
    model_reset();
    repeat (3) tick();
    check_outs("por", 1'b0);
    reset = 1'b0;
    tick();
    tick();

    // Eight identical complete packets, ch6 at full scale
    d5 = '{'h100, 'h200, 'h300, 'h400, 'hFFF};
    for (int p = 0; p < WIN; p++) begin
      make_good(d5, 0, cq, dq);
      send_pkt("fixed", cq, dq);
    end
    check("fixed.ch4_full", avg_ch4, 12'hFFF);
    check("fixed.seq1", avg_seq, 8'd1);
    tick();
    check("fixed.pulse_one_cycle", avg_valid, 1'b0);

    // Beat with no preceding SOP, then err_clr
    beat(1, 7, 0, 0);
    err_m[2] = 1'b1;
    check("nosop.err", err, err_m);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    err_m = '0;
    check("errclr.err", err, err_m);

    // SOP inside a packet: partial dropped, restarted packet counts
    beat(1, 11, 1, 0);
    beat(2, 22, 0, 0);
    err_m[1] = 1'b1;
    good_pkt("sop_restart", 0);
    check("sop_restart.err1", err[1], 1'b1);

    // Single SOP+EOP beat is an incomplete packet
    cq = {1};
    dq = {5};
    send_pkt("sop_eop", cq, dq);

    // Reset held three cycles mid-packet
    beat(1, 5, 1, 0);
    beat(2, 6, 0, 0);
    reset = 1'b1;
    rsp.valid = 1'b1;
    rsp.channel = 5'd3;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      check_outs("reset_mid", 1'b0);
    end
    reset = 1'b0;
    rsp.valid = 1'b0;
    tick();
    tick();

    // Random windows with unmapped beats interleaved
    for (int p = 0; p < 3 * WIN; p++) good_pkt("rand", int'($urandom_range(0, 2)));

    // Discards inside a window: one missing ch6, one with ch2 twice
    for (int p = 0; p < 3; p++) good_pkt("disc_pre", 1);
    rand_data(d5);
    cq = {1, 2, 3, 4};
    dq = {d5[0], d5[1], d5[2], d5[3]};
    send_pkt("disc_miss6", cq, dq);
    check("disc_miss6.err0", err[0], 1'b1);
    for (int p = 0; p < 2; p++) good_pkt("disc_mid", 0);
    rand_data(d5);
    cq = {1, 2, 3, 2, 4, 6};
    dq = {d5[0], d5[1], d5[2], 4095, d5[3], d5[4]};
    send_pkt("disc_dup2", cq, dq);
    for (int p = 0; p < 3; p++) good_pkt("disc_post", 0);

    // Enable drop after five packets: window restarts, outputs hold
    for (int p = 0; p < 5; p++) good_pkt("en_pre", 0);
    enable = 1'b0;
    model_clear();
    tick();
    beat(1, 99, 0, 0);
    tick();
    check_outs("en_low", 1'b0);
    enable = 1'b1;
    tick();
    for (int p = 0; p < WIN; p++) good_pkt("en_post", 1);

    // Rounding: ch1 = 0 x7 then 4 x1
    enable = 1'b0;
    model_clear();
    tick();
    enable = 1'b1;
    tick();
    for (int p = 0; p < WIN; p++) begin
      rand_data(d5);
      d5[0] = (p == WIN - 1) ? 4 : 0;
      make_good(d5, 0, cq, dq);
      send_pkt("round", cq, dq);
    end
`ifdef ADC_AVG_ROUND_EN
    check("round.ch0", avg_ch0, 12'd1);
`else
    check("round.ch0", avg_ch0, 12'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_chan_avg.md
# adc_chan_avg

Per-channel ADC averaging stage between the Modular ADC sequencer response stream and the I2C-visible channel registers. It consumes Avalon-ST response beats on `clk_core` and stages one sample per mapped channel for each sequencer packet. Only complete packets are committed to per-channel accumulators. After 2^AVG_LOG2 committed packets it publishes a coherent set of five 12-bit averages, which replace raw last-sample capture.

## Interface
- AVG_LOG2, 3: log2 of packets averaged per published set; legal range 1..6.
- clk_core  in  1  50 MHz core clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  ADC run state (I2C control reg bit 0); low halts and flushes averaging.
- adc_response_valid  in  1  response beat valid; no backpressure, a beat may arrive every cycle.
- adc_response_channel  in  5  sequencer channel number.
- adc_response_data  in  12  sample.
- adc_response_startofpacket  in  1  first beat of sequence.
- adc_response_endofpacket  in  1  last beat of sequence.
- err_clr  in  1  clears `err` (one-cycle pulse).
- avg_ch0..avg_ch4  out  12 each  published averages for channels 1,2,3,4,6; reset 0.
- avg_valid  out  1  one-cycle pulse on publish; reset 0.
- avg_seq  out  8  publish counter, wraps 255→0; reset 0.
- err  out  3  sticky: [0] packet discarded, [1] SOP inside packet, [2] beat outside packet; reset 0.

## Operation
- Slot map: channel 1→slot0, 2→1, 3→2, 4→3, 6→4. Other channels are ignored and do not set an error.
- FSM states:
  - IDLE: entered on reset or `enable`=0.
  - WAIT_SOP: entered from IDLE when `enable`=1.
  - IN_PKT: entered from WAIT_SOP on a valid SOP beat.
- Leaving IDLE, or `enable` falling in any state, clears the seen mask, staging registers, accumulators and packet count. `avg_ch*` and `avg_seq` hold their values.
- IN_PKT, valid beat for a mapped slot:
  - Slot not yet seen: stage[slot]←data and set its seen bit.
  - Slot already seen (duplicate): set a packet-bad flag.
- Valid EOP beat in IN_PKT:
  - Mask all-ones and not bad: commit acc[s]+=stage[s] for all slots and increment the packet count.
  - Otherwise: discard the packet and set err[0].
  - Next state is WAIT_SOP either way.
- SOP beat while in IN_PKT: set err[1], drop the partial packet and restart with this beat as the packet's first beat.
- Beat with SOP and EOP both set: processed as SOP then EOP in the same cycle. An incomplete mask means discard.
- Valid beat in WAIT_SOP without SOP: ignored, sets err[2]. Valid beats in IDLE are ignored silently.
- Accumulator width is 12+AVG_LOG2. It cannot overflow: max 4095·2^N.
- Publish happens on the commit that brings the count to 2^AVG_LOG2:
  - avg_ch[s] ← f(acc[s]+stage[s]).
  - Accumulators and count clear.
  - avg_seq increments and avg_valid pulses.
- err bits: set has priority over err_clr in the same cycle.

## Timing
- Staging update: registered at the clock edge after the beat.
- EOP beat sampled at edge T: commit occurs at edge T. On the publish packet, avg_ch*, avg_seq and avg_valid=1 are visible in the cycle after T. avg_valid is high for exactly one cycle.
- Back-to-back packets with a new SOP in the cycle after EOP are accepted with no lost beats.
- reset mid-packet returns to IDLE next cycle with all outputs at reset values.

## Configuration
- ADC_AVG_ROUND_EN defined: f(x) = (x + 2^(AVG_LOG2-1)) >> AVG_LOG2, i.e. round half up. It never exceeds 4095; the adder is one bit wider than acc.
- Undefined: f(x) = x >> AVG_LOG2 (truncate).

## Structure
- Package `adc_avg_pkg`:
  - NUM_SLOTS=5.
  - Slot channel-number constants.
  - Error bit indices.
  - FSM state enum.
- Sub-module `adc_avg_slot`, one instance per slot: stage register, seen bit, accumulator, rounding/shift and output register. It is controlled by load, commit, publish and flush strobes from the parent FSM.

## Test plan
- Reset: hold reset 3 cycles mid-stream → all avg_ch*=0, avg_valid=0, avg_seq=0, err=0.
- 8 complete packets (ch1=0x100, ch2=0x200, ch3=0x300, ch4=0x400, ch6=0xFFF), AVG_LOG2=3 → single avg_valid pulse one cycle after 8th EOP; avg_ch0..4=0x100,0x200,0x300,0x400,0xFFF; avg_seq=1; no overflow.
- Rounding: ch1 = 0 for 7 packets, 4 in 1 packet → avg_ch0=1 with ADC_AVG_ROUND_EN, 0 without.
- Discard: packet missing ch6, then packet with ch2 twice, within an 8-packet window → err[0]=1; publish only after 8 complete packets; averages exclude the bad packets' data.
- Framing: SOP mid-packet → err[1]=1 and the restarted packet counts; data beat before any SOP → err[2]=1; err_clr → err=0 next cycle.
- Enable drop after 5 committed packets, then re-enable → no publish until 8 new complete packets; avg_ch* hold previous values throughout.
